pzcorebus_upsizer_response_path: RTL and testbench

Response-side companion of the corebus upsizer. It converts wide master-side read-response beats of NARROW_DATA_WIDTH*CONVERSION_RATIO bits into narrow slave-side beats by unpacking lanes, starting at the command's address offset and stopping after the requested narrow length. Per-read-command info (start lane, narrow beat count) arrives from the request path through a small in-order info FIFO. Responses without data pass through 1:1.

---
 rtl/pzcorebus_upsizer_response_path.sv | 117 +++++++++++
 tb/tb_pzcorebus_upsizer_response_path.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pzcorebus_upsizer_response_path.sv
// rtl/pzcorebus_upsizer_response_path.sv - unpacks wide read-response beats into narrow beats
// Per-read start lane and length come from the request path through an in-order info FIFO.
module pzcorebus_upsizer_response_path #(
  parameter  int NARROW_DATA_WIDTH = 32,
  parameter  int CONVERSION_RATIO  = 4,
  parameter  int ID_WIDTH          = 8,
  parameter  int RESP_WIDTH        = 2,
  parameter  int LENGTH_WIDTH      = 8,
  parameter  int INFO_DEPTH        = 4,
  localparam int LW                = $clog2(CONVERSION_RATIO),
  localparam int WIDE              = NARROW_DATA_WIDTH * CONVERSION_RATIO
)(
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_info_valid,
  output logic                         o_info_ready,
  input  logic [LW-1:0]                i_info_offset,
  input  logic [LENGTH_WIDTH-1:0]      i_info_length,
  input  logic                         i_wide_sresp_valid,
  output logic                         o_wide_mresp_accept,
  input  logic [RESP_WIDTH-1:0]        i_wide_sresp,
  input  logic [ID_WIDTH-1:0]          i_wide_sid,
  input  logic                         i_wide_has_data,
  input  logic [WIDE-1:0]              i_wide_sdata,
  input  logic                         i_wide_sresp_last,
  output logic                         o_narrow_sresp_valid,
  input  logic                         i_narrow_mresp_accept,
  output logic [RESP_WIDTH-1:0]        o_narrow_sresp,
  output logic [ID_WIDTH-1:0]          o_narrow_sid,
  output logic [NARROW_DATA_WIDTH-1:0] o_narrow_sdata,
  output logic                         o_narrow_sresp_last
);

  localparam int AW = $clog2(INFO_DEPTH);

  logic [LW-1:0]           info_offset [INFO_DEPTH];
  logic [LENGTH_WIDTH-1:0] info_length [INFO_DEPTH];
  logic [AW:0]             wr_ptr;
  logic [AW:0]             rd_ptr;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;

  logic                    busy_q;
  logic [LW-1:0]           lane_q;
  logic [LENGTH_WIDTH-1:0] rem_q;

  logic [LW-1:0]           lane;
  logic [LENGTH_WIDTH-1:0] rem;
  logic [LW-1:0]           sel_lane;
  logic                    data_valid;
  logic                    data_last;
  logic                    data_hs;
  logic [NARROW_DATA_WIDTH-1:0] lanes [CONVERSION_RATIO];

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign o_info_ready = !fifo_full;
  assign push         = i_info_valid && !fifo_full;

  always_ff @(posedge i_clk) begin
    if (push) begin
      info_offset[wr_ptr[AW-1:0]] <= i_info_offset;
      info_length[wr_ptr[AW-1:0]] <= i_info_length;
    end
  end

  for (genvar g = 0; g < CONVERSION_RATIO; g++) begin : g_lane
    assign lanes[g] = i_wide_sdata[g*NARROW_DATA_WIDTH +: NARROW_DATA_WIDTH];
  end

  // The head of the FIFO is only consulted for the first narrow beat of a read.
  assign lane       = busy_q ? lane_q : info_offset[rd_ptr[AW-1:0]];
  assign rem        = busy_q ? rem_q  : info_length[rd_ptr[AW-1:0]];
  assign data_valid = i_wide_sresp_valid && !fifo_empty;
  assign data_last  = (rem == LENGTH_WIDTH'(1));
  assign data_hs    = i_wide_has_data && data_valid && i_narrow_mresp_accept;
  assign pop        = data_hs && data_last;

  always_comb begin
    o_narrow_sresp_valid = i_wide_sresp_valid;
    o_narrow_sresp_last  = i_wide_sresp_last;
    o_wide_mresp_accept  = i_wide_sresp_valid && i_narrow_mresp_accept;
    sel_lane             = '0;
    if (i_wide_has_data) begin
      o_narrow_sresp_valid = data_valid;
      o_narrow_sresp_last  = data_last;
      o_wide_mresp_accept  = data_hs && ((lane == LW'(CONVERSION_RATIO - 1)) || data_last);
      sel_lane             = lane;
    end
  end

  assign o_narrow_sresp = i_wide_sresp;
  assign o_narrow_sid   = i_wide_sid;
  assign o_narrow_sdata = lanes[sel_lane];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      busy_q <= 1'b0;
      lane_q <= '0;
      rem_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (data_hs) begin
        busy_q <= !data_last;
        lane_q <= lane + LW'(1);
        rem_q  <= rem - LENGTH_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_pzcorebus_upsizer_response_path.sv
// tb/tb_pzcorebus_upsizer_response_path.sv - directed bench for the upsizer response path
module tb_pzcorebus_upsizer_response_path;
  localparam int N    = 32;
  localparam int R    = 4;
  localparam int WIDE = N * R;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            info_valid;
  logic            info_ready;
  logic [1:0]      info_offset;
  logic [7:0]      info_length;
  logic            w_valid;
  logic            w_accept;
  logic [1:0]      w_sresp;
  logic [7:0]      w_sid;
  logic            w_has_data;
  logic [WIDE-1:0] w_sdata;
  logic            w_last;
  logic            n_valid;
  logic            n_accept;
  logic [1:0]      n_sresp;
  logic [7:0]      n_sid;
  logic [N-1:0]    n_sdata;
  logic            n_last;

  logic [N+2:0]    got;
  logic [N+2:0]    exp;
  int              n_checks = 0;
  int              n_fail = 0;

  always #5 clk = ~clk;

  pzcorebus_upsizer_response_path dut (
    .i_clk                 (clk),
    .i_rst_n               (rst_n),
    .i_info_valid          (info_valid),
    .o_info_ready          (info_ready),
    .i_info_offset         (info_offset),
    .i_info_length         (info_length),
    .i_wide_sresp_valid    (w_valid),
    .o_wide_mresp_accept   (w_accept),
    .i_wide_sresp          (w_sresp),
    .i_wide_sid            (w_sid),
    .i_wide_has_data       (w_has_data),
    .i_wide_sdata          (w_sdata),
    .i_wide_sresp_last     (w_last),
    .o_narrow_sresp_valid  (n_valid),
    .i_narrow_mresp_accept (n_accept),
    .o_narrow_sresp        (n_sresp),
    .o_narrow_sid          (n_sid),
    .o_narrow_sdata        (n_sdata),
    .o_narrow_sresp_last   (n_last)
  );

  // {valid, data, last, wide accept} observed as one vector per narrow beat
  assign got = {n_valid, n_sdata, n_last, w_accept};

  function automatic logic [N-1:0] lane_val(input int beat, input int k);
    return 32'hA000_0000 | N'(beat << 8) | N'(k);
  endfunction

  function automatic logic [WIDE-1:0] mk(input int beat);
    logic [WIDE-1:0] v;
    for (int k = 0; k < R; k++) v[k*N +: N] = lane_val(beat, k);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    info_valid  = 1'b0;
    info_offset = '0;
    info_length = '0;
    w_valid     = 1'b0;
    w_sresp     = '0;
    w_sid       = 8'h5A;
    w_has_data  = 1'b0;
    w_sdata     = '0;
    w_last      = 1'b0;
    n_accept    = 1'b0;
  endtask

  task automatic push_info(input logic [1:0] off, input logic [7:0] len);
    info_valid  = 1'b1;
    info_offset = off;
    info_length = len;
    tick();
    info_valid  = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    tick();
    rst_n = 1'b1;
    #3;
    n_checks++;
    if (n_valid !== 1'b0 || w_accept !== 1'b0 || info_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: valid=%b accept=%b ready=%b expected 0 0 1", n_valid, w_accept, info_ready);
    end
    tick();
  endtask

  task automatic test_aligned();
    int widx = 0;
    push_info(2'd0, 8'd8);
    for (int b = 0; b < 8; b++) begin
      w_valid = 1'b1; w_has_data = 1'b1; n_accept = 1'b1; w_sdata = mk(widx);
      #3;
      exp = {1'b1, lane_val(widx, b % 4), b == 7, (b == 3) || (b == 7)};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL aligned beat %0d: got %h expected %h", b, got, exp);
      end
      if (b == 3) widx++;
      tick();
    end
    w_sdata = mk(5);
    #3;
    n_checks++;
    if (n_valid !== 1'b0 || w_accept !== 1'b0) begin
      n_fail++;
      $display("FAIL aligned_empty: valid=%b accept=%b expected 0 0", n_valid, w_accept);
    end
    idle();
  endtask

  task automatic test_offset_span();
    int lanes [3] = '{2, 3, 0};
    int wbeat [3] = '{0, 0, 1};
    bit acc   [3] = '{1'b0, 1'b1, 1'b1};
    push_info(2'd2, 8'd3);
    for (int b = 0; b < 3; b++) begin
      w_valid = 1'b1; w_has_data = 1'b1; n_accept = 1'b1; w_sdata = mk(wbeat[b] + 10);
      #3;
      exp = {1'b1, lane_val(wbeat[b] + 10, lanes[b]), b == 2, acc[b]};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL offset_span beat %0d: got %h expected %h", b, got, exp);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_single_wide();
    push_info(2'd1, 8'd2);
    for (int b = 0; b < 2; b++) begin
      w_valid = 1'b1; w_has_data = 1'b1; n_accept = 1'b1; w_sdata = mk(20);
      #3;
      exp = {1'b1, lane_val(20, b + 1), b == 1, b == 1};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL single_wide beat %0d: got %h expected %h", b, got, exp);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_stall_empty();
    w_valid = 1'b1; w_has_data = 1'b1; n_accept = 1'b1; w_sdata = mk(30);
    for (int c = 0; c < 5; c++) begin
      #3;
      n_checks++;
      if (n_valid !== 1'b0 || w_accept !== 1'b0) begin
        n_fail++;
        $display("FAIL stall cycle %0d: valid=%b accept=%b expected 0 0", c, n_valid, w_accept);
      end
      tick();
    end
    info_valid = 1'b1; info_offset = 2'd0; info_length = 8'd4;
    #3;
    n_checks++;
    if (n_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_push_cycle: valid=%b expected 0", n_valid);
    end
    tick();
    info_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      #3;
      exp = {1'b1, lane_val(30, b), b == 3, b == 3};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL stall_release beat %0d: got %h expected %h", b, got, exp);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_nondata_interleave();
    push_info(2'd0, 8'd4);
    w_valid = 1'b1; w_has_data = 1'b1; n_accept = 1'b1; w_sdata = mk(40); w_sid = 8'h5A;
    #3;
    exp = {1'b1, lane_val(40, 0), 1'b0, 1'b0};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL nondata_pre: got %h expected %h", got, exp);
    end
    tick();
    w_has_data = 1'b0; w_sid = 8'h12; w_last = 1'b1; w_sresp = 2'b01; w_sdata = mk(41);
    for (int c = 0; c < 2; c++) begin
      n_accept = (c == 1);
      #3;
      exp = {1'b1, lane_val(41, 0), 1'b1, c == 1};
      n_checks++;
      if (got !== exp || n_sid !== 8'h12 || n_sresp !== 2'b01) begin
        n_fail++;
        $display("FAIL nondata cycle %0d: got %h sid %h resp %b expected %h sid 12 resp 01",
                 c, got, n_sid, n_sresp, exp);
      end
      tick();
    end
    w_has_data = 1'b1; w_sid = 8'h5A; w_last = 1'b0; w_sresp = 2'b00; w_sdata = mk(40); n_accept = 1'b1;
    for (int b = 1; b < 4; b++) begin
      #3;
      exp = {1'b1, lane_val(40, b), b == 3, b == 3};
      n_checks++;
      if (got !== exp || n_sid !== 8'h5A) begin
        n_fail++;
        $display("FAIL nondata_post beat %0d: got %h sid %h expected %h sid 5a", b, got, n_sid, exp);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_full_and_reset();
    info_valid = 1'b1; info_offset = 2'd0; info_length = 8'd2;
    for (int c = 0; c < 4; c++) tick();
    #3;
    n_checks++;
    if (info_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready: ready=%b expected 0", info_ready);
    end
    tick();
    info_valid = 1'b0;
    w_valid = 1'b1; w_has_data = 1'b1; n_accept = 1'b1; w_sdata = mk(50);
    for (int b = 0; b < 2; b++) begin
      #3;
      exp = {1'b1, lane_val(50, b), b == 1, b == 1};
      n_checks++;
      if (got !== exp || info_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL full_drain beat %0d: got %h ready %b expected %h ready 0", b, got, info_ready, exp);
      end
      tick();
    end
    w_sdata = mk(51);
    #3;
    n_checks++;
    if (info_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_pop: ready=%b expected 1", info_ready);
    end
    exp = {1'b1, lane_val(51, 0), 1'b0, 1'b0};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL pre_reset_beat: got %h expected %h", got, exp);
    end
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (n_valid !== 1'b0 || w_accept !== 1'b0 || info_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%b accept=%b ready=%b expected 0 0 1", n_valid, w_accept, info_ready);
    end
    tick();
    rst_n = 1'b1;
    w_valid = 1'b0;
    push_info(2'd3, 8'd1);
    w_valid = 1'b1; w_sdata = mk(52);
    #3;
    exp = {1'b1, lane_val(52, 3), 1'b1, 1'b1};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL post_reset_lane: got %h expected %h", got, exp);
    end
    tick();
    idle();
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_offset_span();
    test_single_wide();
    test_stall_empty();
    test_nondata_interleave();
    test_full_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
